balance_cntrl_pipe: RTL
=======================

# balance_cntrl_pipe

Parametrised, fully pipelined balance controller for the Segway drive path. It turns inertial pitch and pitch-rate samples plus rider inputs into signed left and right motor speed commands. It contains a saturating PID, a soft-start ramp, steering mix, an optional dead-zone compensation stage and a configurable number of retiming stages for closing max-delay timing. It sits between the inertial interface and the motor PWM drivers.

## Interface
- PTCH_W, 16: width of signed ptch and ptch_rt inputs (≥10).
- PIPE_STG, 1: extra retiming flop stages on the PID result (0–3).
- FAST_SIM, 1: 1 selects a 9-bit soft-start counter; 0 selects a 27-bit counter.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- vld  in  1  new ptch/ptch_rt sample this cycle.
- ptch, ptch_rt  in  PTCH_W  signed pitch and pitch rate.
- pwr_up  in  1  rider authorises power.
- rider_off  in  1  no rider detected.
- en_steer  in  1  enables steering mix.
- steer_pot  in  12  unsigned steering potentiometer value.
- lft_spd, rght_spd  out  12  signed motor speed commands.
- spd_vld  out  1  one-cycle pulse when new speeds are presented.
- too_fast  out  1  overspeed flag.

## Operation
- Error saturation: e = ptch saturated to signed 10 bits [-512, 511].
- P term: P = e × 5 (signed 15 bits).
- D term: D = −(ptch_rt >>> 6), saturated to signed 15 bits.
- Integrator: signed 18 bits.
  - On vld && pwr_up && !rider_off: integ += sign-extended e, saturating at ±(2^17−1).
  - Cleared to 0 whenever rider_off or !pwr_up.
- I term: I = integ >>> (FAST_SIM ? 1 : 6), saturated to signed 15 bits.
- PID output: PID = P + I + D (17 bits), saturated to signed 12 bits.
- Soft-start counter:
  - Increments every clk while pwr_up, saturating at all-ones; cleared when !pwr_up.
  - ss_tmr is the counter's upper 8 bits.
- Scaling: S = (PID × ss_tmr) >>> 8, signed 12 bits.
- Steering operand: st = clip(steer_pot, 0x200, 0xE00) − 0x7FF. The steering term is (st × 3) >>> 4 (arithmetic, floor).
- Mix:
  - en_steer=1: lft = S + steer, rght = S − steer.
  - en_steer=0: lft = rght = S.
  - Both are 13-bit sums, saturated to signed 12 bits.
- Overspeed: too_fast = (lft_mix > 1536) || (rght_mix > 1536), signed compare on the mix values before dead-zone compensation.
- Power-down: !pwr_up forces lft_spd, rght_spd and too_fast to 0 at the output register on the next clk, regardless of pipeline contents.

## Timing
- Reset values: all outputs 0; integrator, ss counter and all pipeline registers 0.
- Stage 1 (on vld): register P, D and e; update the integrator.
- Stage 2: register the saturated PID and the valid bit.
- Stages 3 … 2+PIPE_STG: PIPE_STG retiming flops carrying the PID and the valid bit.
- Output stage: registers the scale, steer mix and dead-zone results into lft_spd, rght_spd and too_fast. ss_tmr and steer_pot are sampled at this stage.
- Latency: spd_vld asserts exactly 3+PIPE_STG clks after vld.
- Throughput: back-to-back vld is accepted every cycle, with no stalls.
- Hold: outputs keep their value between spd_vld pulses.
- vld while !pwr_up still propagates spd_vld; the outputs are 0.
- pwr_up falls mid-pipeline: in-flight samples emerge with zero outputs.
- rider_off asserted on the same cycle as vld: the integrator clears and does not accumulate.

## Configuration
- BAL_DEADZONE_EN defined: dead-zone compensation applies to each mixed speed x.
  - |x| ≥ 0x3C: x + sign(x)×0xB4.
  - |x| < 0x3C: x × 4.
  - Result saturated to signed 12 bits.
- BAL_DEADZONE_EN undefined: mixed speeds pass straight to the output register.

## Structure
- Shared package bal_pkg holds these constants:
  - P_COEFF=5, D_SHIFT=6, I_SHIFT_FAST=1, I_SHIFT_SLOW=6.
  - STEER_MIN=0x200, STEER_MAX=0xE00, STEER_MID=0x7FF.
  - TOO_FAST_THR=1536, LOW_TORQUE_BAND=0x3C, MIN_DUTY=0xB4.
  - A sat12 saturation function.
- Sub-module bal_pid_core holds stages 1–2 (error saturation, P/I/D, integrator, PID sum).
- The top level holds the soft-start counter, retiming chain, mix and output stage.

## Test plan
- Reset check: assert rst_n low mid-run → all outputs 0 and spd_vld 0 immediately; after release, the first spd_vld comes only after a new vld.
- Basic P path: pwr_up=1 for 600 clks (FAST_SIM=1, ss_tmr=255), rider_off=1, ptch=0x0010, ptch_rt=0, en_steer=0, vld pulse → after 3+PIPE_STG clks, lft=rght=79. With BAL_DEADZONE_EN defined, both are 259.
- Saturation: ss_tmr=255, ptch=0x7FFF → PID=2047, lft=rght=2039, too_fast=1.
- Steering: ptch=0, en_steer=1, steer_pot=0xFFF → lft=288, rght=0xEE0. With steer_pot=0x000 → lft=0xEE0, rght=288.
- Integrator: rider_off=0, ptch=0x0020, ptch_rt=0, 100 vld pulses → integ=3200, I=1600, PID=1760. Then pulse rider_off → integ=0 and the next PID is 160.
- Power-down mid-pipeline: drop pwr_up one clk after vld → outputs 0 on the following clk, ss_tmr 0, and spd_vld still pulses at the nominal latency.

Source files
------------

// File: rtl/bal_pkg.sv
// Shared constants, types and saturation helpers for the balance controller.
// Included by bal_pid_core and balance_cntrl_pipe.

package bal_pkg;

    localparam int P_COEFF      = 5;
    localparam int D_SHIFT      = 6;
    localparam int I_SHIFT_FAST = 1;
    localparam int I_SHIFT_SLOW = 6;

    localparam logic [11:0] STEER_MIN = 12'h200;
    localparam logic [11:0] STEER_MAX = 12'hE00;
    localparam logic [11:0] STEER_MID = 12'h7FF;

    localparam logic signed [11:0] TOO_FAST_THR    = 12'sd1536;
    localparam logic signed [11:0] LOW_TORQUE_BAND = 12'sh03C;
    localparam logic signed [11:0] MIN_DUTY        = 12'sh0B4;

    typedef logic signed [11:0] spd_t;

    typedef struct packed {
        spd_t lft;
        spd_t rght;
        logic too_fast;
    } spd_cmd_t;

    function automatic spd_t sat12(input logic signed [17:0] x);
        if (x > 18'sd2047) begin
            return 12'sh7FF;
        end
        if (x < -18'sd2048) begin
            return 12'sh800;
        end
        return 12'(x);
    endfunction

    // Pushes small commands past motor stiction: small values are amplified,
    // larger ones get a fixed minimum-duty offset away from zero.
    function automatic spd_t dead_zone(input spd_t x);
        logic signed [13:0] y;
        if (x >= LOW_TORQUE_BAND) begin
            y = 14'(x) + 14'(MIN_DUTY);
        end else if (x <= -LOW_TORQUE_BAND) begin
            y = 14'(x) - 14'(MIN_DUTY);
        end else begin
            y = 14'(x) <<< 2;
        end
        return sat12(18'(y));
    endfunction

endpackage

// File: rtl/bal_pid_core.sv
// PID front end of the balance controller: error saturation, P/I/D terms,
// saturating integrator (stage 1) and the saturated PID sum (stage 2).

module bal_pid_core
    import bal_pkg::*;
#(
    parameter int unsigned PTCH_W   = 16,
    parameter bit          FAST_SIM = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vld_i,
    input  logic signed [PTCH_W-1:0] ptch_i,
    input  logic signed [PTCH_W-1:0] ptch_rt_i,
    input  logic                     pwr_up_i,
    input  logic                     rider_off_i,
    output spd_t                     pid_o,
    output logic                     pid_vld_o
);

    localparam int unsigned WW      = (PTCH_W + 2 > 20) ? PTCH_W + 2 : 20;
    localparam int          I_SHIFT = FAST_SIM ? I_SHIFT_FAST : I_SHIFT_SLOW;

    function automatic logic signed [9:0] sat10(input logic signed [WW-1:0] x);
        if (x > WW'(511)) begin
            return 10'sh1FF;
        end
        if (x < -WW'(512)) begin
            return 10'sh200;
        end
        return 10'(x);
    endfunction

    function automatic logic signed [14:0] sat15(input logic signed [WW-1:0] x);
        if (x > WW'(16383)) begin
            return 15'sh3FFF;
        end
        if (x < -WW'(16384)) begin
            return 15'sh4000;
        end
        return 15'(x);
    endfunction

    logic signed [9:0]  err;
    logic signed [14:0] p_d, p_q;
    logic signed [14:0] d_d, d_q;
    logic signed [14:0] i_term;
    logic signed [17:0] integ_d, integ_q;
    logic signed [18:0] integ_sum;
    logic signed [17:0] pid_sum;
    spd_t               pid_d, pid_q;
    logic               s1_vld_q, s2_vld_q;

    always_comb begin
        err       = sat10(WW'(ptch_i));
        p_d       = 15'(err) * 15'(P_COEFF);
        d_d       = sat15(-(WW'(ptch_rt_i) >>> D_SHIFT));
        integ_sum = 19'(integ_q) + 19'(err);
        integ_d   = integ_q;
        // Rider loss or power removal always wins over accumulation.
        if (!pwr_up_i || rider_off_i) begin
            integ_d = '0;
        end else if (vld_i) begin
            if (integ_sum > 19'sd131071) begin
                integ_d = 18'sd131071;
            end else if (integ_sum < -19'sd131071) begin
                integ_d = -18'sd131071;
            end else begin
                integ_d = 18'(integ_sum);
            end
        end
        i_term  = sat15(WW'(integ_q) >>> I_SHIFT);
        pid_sum = 18'(p_q) + 18'(i_term) + 18'(d_q);
        pid_d   = sat12(pid_sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q      <= '0;
            d_q      <= '0;
            integ_q  <= '0;
            s1_vld_q <= 1'b0;
            pid_q    <= '0;
            s2_vld_q <= 1'b0;
        end else begin
            integ_q  <= integ_d;
            s1_vld_q <= vld_i;
            s2_vld_q <= s1_vld_q;
            if (vld_i) begin
                p_q <= p_d;
                d_q <= d_d;
            end
            if (s1_vld_q) begin
                pid_q <= pid_d;
            end
        end
    end

    assign pid_o     = pid_q;
    assign pid_vld_o = s2_vld_q;

endmodule

// File: rtl/balance_cntrl_pipe.sv
// Pipelined Segway balance controller: PID core, soft-start, retiming, steering mix.
// Optional dead-zone compensation is enabled by defining BAL_DEADZONE_EN.

module balance_cntrl_pipe
    import bal_pkg::*;
#(
    parameter int unsigned PTCH_W   = 16,
    parameter int unsigned PIPE_STG = 1,
    parameter bit          FAST_SIM = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vld_i,
    input  logic signed [PTCH_W-1:0] ptch_i,
    input  logic signed [PTCH_W-1:0] ptch_rt_i,
    input  logic                     pwr_up_i,
    input  logic                     rider_off_i,
    input  logic                     en_steer_i,
    input  logic [11:0]              steer_pot_i,
    output logic signed [11:0]       lft_spd_o,
    output logic signed [11:0]       rght_spd_o,
    output logic                     spd_vld_o,
    output logic                     too_fast_o
);

    localparam int unsigned SS_W = FAST_SIM ? 9 : 27;

    spd_t pid_s2, pid_rt;
    logic vld_s2, vld_rt;

    bal_pid_core #(
        .PTCH_W   (PTCH_W),
        .FAST_SIM (FAST_SIM)
    ) u_pid_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .vld_i       (vld_i),
        .ptch_i      (ptch_i),
        .ptch_rt_i   (ptch_rt_i),
        .pwr_up_i    (pwr_up_i),
        .rider_off_i (rider_off_i),
        .pid_o       (pid_s2),
        .pid_vld_o   (vld_s2)
    );

    // Soft-start ramp: saturating counter, upper 8 bits scale the PID.
    logic [SS_W-1:0] ss_cnt_d, ss_cnt_q;
    logic [7:0]      ss_tmr;

    always_comb begin
        ss_cnt_d = ss_cnt_q;
        if (!pwr_up_i) begin
            ss_cnt_d = '0;
        end else if (!(&ss_cnt_q)) begin
            ss_cnt_d = ss_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_cnt_q <= '0;
        end else begin
            ss_cnt_q <= ss_cnt_d;
        end
    end

    assign ss_tmr = ss_cnt_q[SS_W-1 -: 8];

    if (PIPE_STG == 0) begin : g_no_retime
        assign pid_rt = pid_s2;
        assign vld_rt = vld_s2;
    end else begin : g_retime
        logic [PIPE_STG-1:0][11:0] pid_q;
        logic [PIPE_STG-1:0]       vld_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pid_q <= '0;
                vld_q <= '0;
            end else begin
                pid_q[0] <= pid_s2;
                vld_q[0] <= vld_s2;
                for (int i = 1; i < PIPE_STG; i++) begin
                    pid_q[i] <= pid_q[i-1];
                    vld_q[i] <= vld_q[i-1];
                end
            end
        end

        assign pid_rt = spd_t'(pid_q[PIPE_STG-1]);
        assign vld_rt = vld_q[PIPE_STG-1];
    end

    logic signed [20:0] scale_prod;
    spd_t               scaled;
    logic [11:0]        pot_clip;
    logic signed [12:0] steer_op;
    logic signed [14:0] steer_x3;
    spd_t               steer;
    logic signed [12:0] lft_sum, rght_sum;
    spd_t               lft_mix, rght_mix;
    spd_cmd_t           cmd_d, cmd_q;
    logic               spd_vld_q;

    always_comb begin
        scale_prod = 21'(pid_rt) * 21'($signed({1'b0, ss_tmr}));
        scaled     = 12'(scale_prod >>> 8);

        if (steer_pot_i < STEER_MIN) begin
            pot_clip = STEER_MIN;
        end else if (steer_pot_i > STEER_MAX) begin
            pot_clip = STEER_MAX;
        end else begin
            pot_clip = steer_pot_i;
        end
        steer_op = $signed({1'b0, pot_clip}) - $signed({1'b0, STEER_MID});
        steer_x3 = 15'(steer_op) * 15'sd3;
        steer    = 12'(steer_x3 >>> 4);

        if (en_steer_i) begin
            lft_sum  = 13'(scaled) + 13'(steer);
            rght_sum = 13'(scaled) - 13'(steer);
        end else begin
            lft_sum  = 13'(scaled);
            rght_sum = 13'(scaled);
        end
        lft_mix  = sat12(18'(lft_sum));
        rght_mix = sat12(18'(rght_sum));

        // Overspeed is judged on the raw mix, ahead of any dead-zone boost.
        cmd_d.too_fast = (lft_mix > TOO_FAST_THR) || (rght_mix > TOO_FAST_THR);
`ifdef BAL_DEADZONE_EN
        cmd_d.lft  = dead_zone(lft_mix);
        cmd_d.rght = dead_zone(rght_mix);
`else
        cmd_d.lft  = lft_mix;
        cmd_d.rght = rght_mix;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q     <= '0;
            spd_vld_q <= 1'b0;
        end else begin
            spd_vld_q <= vld_rt;
            if (!pwr_up_i) begin
                cmd_q <= '0;
            end else if (vld_rt) begin
                cmd_q <= cmd_d;
            end
        end
    end

    assign lft_spd_o  = cmd_q.lft;
    assign rght_spd_o = cmd_q.rght;
    assign too_fast_o = cmd_q.too_fast;
    assign spd_vld_o  = spd_vld_q;

endmodule
